subneg_register: RTL and testbench
==================================

# subneg_register

Parameterized edge-triggered storage register used as the basic state element of the SUBNEG datapath (e.g. program counter, operand and accumulator latches). On every rising clock edge it captures its data input and holds it on its output until the next edge. An asynchronous active-low reset forces the stored value to a known constant. There is no enable: the register loads every cycle.

## Interface
- WIDTH, default 8: data width in bits; legal range 1..64.
- RESET_VALUE, default '0 (all zeros): value loaded on reset; truncated or zero-extended to WIDTH.
- clock  input  1  rising-edge sampling clock; single clock domain.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
- in  input  WIDTH  data to be captured.
- out  output  WIDTH  registered value; driven directly from the storage flops, with no combinational path from `in`.

## Operation
- Reset asserted (reset = 0): `out` becomes RESET_VALUE immediately, independent of clock. It stays at RESET_VALUE for as long as reset is low, and clock edges are ignored.
- Normal operation (reset = 1): at each rising edge of `clock`, `out` takes the value of `in` sampled at that edge.
- Between edges, `out` holds its value regardless of activity on `in`.
- Repeated writes of the same value leave `out` unchanged, with no glitch.
- All WIDTH bits are loaded together. There are no partial or byte writes and no arithmetic.
- X or Z on `in` propagates to `out` at the next edge. No sanitization is performed.

## Timing
- Latency: 1 clock. A value presented before rising edge N appears on `out` just after edge N, after the clock-to-q delay.
- Reset assertion is asynchronous and takes effect at the falling edge of `reset`, with no clock required.
- Reset deassertion (rising edge of `reset`) is consumed synchronously:
  - The first capture occurs at the first rising clock edge strictly after deassertion.
  - Deassertion coincident with a clock edge is not a supported condition. Upstream logic must synchronize reset release.
- Reset asserted mid-operation overrides any pending capture. The value captured on the previous edge is lost.
- Reset has priority over clock when both are active.
- `out` is defined from the first reset assertion onward. Before the first reset its value is unspecified (X in simulation).

## Test plan
- Reset: `clock` 10 ns period; drive reset=0 with in=0x00 for 10 ns -> out=0x00 both during reset and at t=10 ns.
- Load: release reset=1 and set in=0xAA at t=10 ns -> out=0xAA after the edge at t=15 ns; check at t=20 ns.
- Overwrite: set in=0x55 at t=20 ns -> out=0x55 after the edge at t=25 ns; check at t=30 ns.
- Hold: keep in=0x55 for another cycle -> out stays 0x55 at t=40 ns with no transition.
- Async reset mid-operation: drive reset=0 at t=40 ns, between edges -> out=0x00 immediately, before the next clock edge. While reset stays low, out stays 0x00 even with in=0x55 across two clock edges.
- Parameter sweep:
  - WIDTH=1 and WIDTH=32 with RESET_VALUE=all ones: reset -> all ones; load alternating patterns (0xA5A5A5A5 / 0x5A5A5A5A for WIDTH=32) -> exact match every cycle.
  - Bit-flip check: for WIDTH=8, load values with a single bit set (0x01, 0x02, ... 0x80) on consecutive cycles -> out matches each value exactly.

Source files
------------

// File: rtl/subneg_register_if.sv
// Data bundle for the SUBNEG storage register.
// The master drives in and observes out; the register is the slave.
interface subneg_register_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;

   modport master (
      output in,
      input  out
   );

   modport slave (
      input  in,
      output out
   );
endinterface

// File: rtl/subneg_register.sv
// Free-running edge-triggered register used for SUBNEG datapath state.
// Loads every rising edge; async active-low reset to RESET_VALUE.
module subneg_register #(
   parameter int          WIDTH       = 8,
   parameter logic [63:0] RESET_VALUE = '0
) (
   input logic               clock,
   input logic               reset,
   subneg_register_if.slave  bus
);
   localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= RST;
      end else begin
         q <= bus.in;
      end
   end

   // out comes straight from the flops; no path from in.
   assign bus.out = q;
endmodule

// File: tb/tb_subneg_register.sv
// Randomized check of subneg_register at WIDTH 8, 1 and 32.
// Expected values come from a capture/reset model kept here.
module tb_subneg_register;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   localparam logic [7:0]  RV8  = 8'h00;
   localparam logic        RV1  = 1'b1;
   localparam logic [31:0] RV32 = 32'hFFFF_FFFF;

   subneg_register_if #(.WIDTH(8))  b8  ();
   subneg_register_if #(.WIDTH(1))  b1  ();
   subneg_register_if #(.WIDTH(32)) b32 ();

   subneg_register #(.WIDTH(8)) u8 (
      .clock (clk),
      .reset (rst),
      .bus   (b8)
   );

   subneg_register #(
      .WIDTH       (1),
      .RESET_VALUE ({64{1'b1}})
   ) u1 (
      .clock (clk),
      .reset (rst),
      .bus   (b1)
   );

   subneg_register #(
      .WIDTH       (32),
      .RESET_VALUE ({64{1'b1}})
   ) u32 (
      .clock (clk),
      .reset (rst),
      .bus   (b32)
   );

   logic [7:0]  e8;
   logic        e1;
   logic [31:0] e32;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_w8"},  {56'd0, b8.out},  {56'd0, e8});
      chk({tag, "_w1"},  {63'd0, b1.out},  {63'd0, e1});
      chk({tag, "_w32"}, {32'd0, b32.out}, {32'd0, e32});
   endtask

   task automatic model_reset();
      e8  = RV8;
      e1  = RV1;
      e32 = RV32;
   endtask

   task automatic model_capture();
      e8  = b8.in;
      e1  = b1.in;
      e32 = b32.in;
   endtask

   // Called at a falling clock edge with reset high: drive, capture, check.
   task automatic cycle(input logic [7:0] d8, input logic d1,
                        input logic [31:0] d32, input bit pulse,
                        input string tag);
      b8.in  = d8;
      b1.in  = d1;
      b32.in = d32;
      @(posedge clk);
      model_capture();
      if (pulse) begin
         #2;
         rst = 1'b0;
         #1;
         model_reset();
         chk_all({tag, "_async"});
      end
      @(negedge clk);
      chk_all(tag);
      rst = 1'b1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      b8.in  = '0;
      b1.in  = '0;
      b32.in = '0;
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk_all("rst_early");
      @(negedge clk);
      chk_all("rst_t10");

      rst = 1'b1;
      cycle(8'hAA, 1'b0, 32'hA5A5_A5A5, 1'b0, "load");
      cycle(8'h55, 1'b1, 32'h5A5A_5A5A, 1'b0, "over");
      #5;
      chk_all("hold_mid");
      @(negedge clk);
      chk_all("hold");

      rst = 1'b0;
      #1;
      model_reset();
      chk_all("mid_rst");
      b8.in  = 8'h55;
      b1.in  = 1'b0;
      b32.in = 32'h1234_5678;
      repeat (2) begin
         @(negedge clk);
         chk_all("rst_held");
      end
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         logic [7:0] one;
         one = 8'h01 << i;
         cycle(one, one[0], {4{one}}, 1'b0, "bit");
      end

      for (int i = 0; i < 4; i++) begin
         cycle(8'hA5, i[0], i[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5,
               1'b0, "alt");
      end

      for (int i = 0; i < 40; i++) begin
         cycle($urandom_range(0, 255), $urandom_range(0, 1), $urandom,
               $urandom_range(0, 7) == 0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end
endmodule
